// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared state encoding and defaults for step_ctrl
// Contents: state_e (HALT/RUN/STEP), default debounce length.
package step_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and rising-edge pulse
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   btn    - raw asynchronous button level
//   pulse  - one-cycle pulse per accepted rising edge of the debounced level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       level_q, level_d;
  logic       level_prev_q, level_prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = 8'd0;
    // Any cycle agreeing with the accepted level restarts the run count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    level_prev_d = level_q;
    // Edge detected from registered levels, so the pulse lands one cycle
    // after the level flips.
    pulse_d      = level_q & ~level_prev_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= 8'd0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - run/halt/single-step controller for a core
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   change_btn, step_btn  - raw run/halt toggle and single-step buttons
//   burst_len             - instructions per step request (0 means 1)
//   instr_done            - one pulse per retired instruction
//   run_en                - core advance enable (RUN or STEP)
//   mode_run, busy        - high in RUN, high in STEP
//   step_count            - completed step bursts, modulo 256
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       change_btn,
  input  logic       step_btn,
  input  logic [3:0] burst_len,
  input  logic       instr_done,
  output logic       run_en,
  output logic       mode_run,
  output logic       busy,
  output logic [7:0] step_count
);

  logic change_pulse;
  logic step_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_change_db (
    .clock (clock),
    .reset (reset),
    .btn   (change_btn),
    .pulse (change_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock (clock),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  state_e     state_q, state_d;
  logic [3:0] remaining_q, remaining_d;
  logic [7:0] step_count_q, step_count_d;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    step_count_d = step_count_q;
    case (state_q)
      ST_HALT: begin
        // Change wins over a simultaneous step request; the step is dropped.
        if (change_pulse) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d     = ST_STEP;
          remaining_d = (burst_len == 4'd0) ? 4'd1 : burst_len;
        end
      end
      ST_RUN: begin
        if (change_pulse) state_d = ST_HALT;
      end
      ST_STEP: begin
        // Abort takes priority over a final retirement in the same cycle.
        if (change_pulse) begin
          state_d     = ST_RUN;
          remaining_d = 4'd0;
        end else if (instr_done) begin
          if (remaining_q == 4'd1) begin
            state_d      = ST_HALT;
            remaining_d  = 4'd0;
            step_count_d = step_count_q + 8'd1;
          end else begin
            remaining_d = remaining_q - 4'd1;
          end
        end
      end
      default: begin
        state_d     = ST_HALT;
        remaining_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HALT;
      remaining_q  <= 4'd0;
      step_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      step_count_q <= step_count_d;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign run_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign mode_run   = (state_q == ST_RUN);
  assign busy       = (state_q == ST_STEP);
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - directed vector bench for step_ctrl
module tb_step_ctrl;

  logic       clock;
  logic       reset;
  logic       change_btn;
  logic       step_btn;
  logic [3:0] burst_len;
  logic       instr_done;
  logic       run_en;
  logic       mode_run;
  logic       busy;
  logic [7:0] step_count;

  step_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .change_btn (change_btn),
    .step_btn   (step_btn),
    .burst_len  (burst_len),
    .instr_done (instr_done),
    .run_en     (run_en),
    .mode_run   (mode_run),
    .busy       (busy),
    .step_count (step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {run_en, mode_run, busy}
  localparam logic [2:0] H = 3'b000;
  localparam logic [2:0] R = 3'b110;
  localparam logic [2:0] S = 3'b101;

  typedef struct {
    logic       chg;
    logic       stp;
    logic [3:0] bl;
    logic       done;
    logic [2:0] st;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(int n, logic chg, logic stp, logic [3:0] bl,
                              logic done, logic [2:0] st, logic [7:0] cnt);
    vec_t v;
    v.chg = chg; v.stp = stp; v.bl = bl; v.done = done; v.st = st; v.cnt = cnt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got run/mode/busy=%b count=%0d, expected run/mode/busy=%b count=%0d",
               name, act[10:8], act[7:0], exp[10:8], exp[7:0]);
    end
  endtask

  function automatic logic [10:0] outs();
    return {run_en, mode_run, busy, step_count};
  endfunction

  task automatic do_burst();
    step_btn = 1'b1;
    burst_len = 4'd1;
    repeat (8) @(posedge clock);
    #1;
    step_btn   = 1'b0;
    instr_done = 1'b1;
    @(posedge clock);
    #1;
    instr_done = 1'b0;
    repeat (8) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; change_btn = 1'b0; step_btn = 1'b0;
    burst_len = 4'd0; instr_done = 1'b0;

    // change press: RUN at 8th edge, then release (falling edge is silent)
    add(7, 1, 0, 0, 0, H, 0); add(5, 1, 0, 0, 0, R, 0); add(8, 0, 0, 0, 0, R, 0);
    // RUN ignores step presses and instr_done
    add(8, 0, 1, 3, 1, R, 0); add(8, 0, 0, 3, 1, R, 0);
    // RUN -> HALT
    add(7, 1, 0, 0, 0, R, 0); add(1, 1, 0, 0, 0, H, 0); add(8, 0, 0, 0, 0, H, 0);
    // 3-cycle glitch rejected; HALT ignores instr_done
    add(3, 1, 0, 0, 1, H, 0); add(10, 0, 0, 0, 1, H, 0);
    // burst of 3; burst_len change and second step press during STEP ignored
    add(7, 0, 1, 3, 0, H, 0); add(1, 0, 1, 3, 0, S, 0); add(8, 0, 0, 9, 0, S, 0);
    add(8, 0, 1, 9, 0, S, 0); add(8, 0, 0, 9, 0, S, 0);
    add(1, 0, 0, 9, 1, S, 0); add(1, 0, 0, 9, 0, S, 0); add(1, 0, 0, 9, 1, S, 0);
    add(1, 0, 0, 9, 1, H, 1); add(2, 0, 0, 0, 0, H, 1);
    // burst_len 0 acts as 1
    add(7, 0, 1, 0, 0, H, 1); add(1, 0, 1, 0, 0, S, 1); add(2, 0, 0, 0, 0, S, 1);
    add(1, 0, 0, 0, 1, H, 2); add(8, 0, 0, 0, 0, H, 2);
    // burst of 5 aborted after 2 by change press
    add(7, 0, 1, 5, 0, H, 2); add(1, 0, 1, 5, 0, S, 2);
    add(2, 0, 0, 5, 1, S, 2);
    add(7, 1, 0, 5, 0, S, 2); add(1, 1, 0, 5, 0, R, 2); add(8, 0, 0, 5, 0, R, 2);
    // back to HALT
    add(7, 1, 0, 0, 0, R, 2); add(1, 1, 0, 0, 0, H, 2); add(8, 0, 0, 0, 0, H, 2);
    // both pressed together in HALT: change wins, step dropped
    add(7, 1, 1, 2, 0, H, 2); add(1, 1, 1, 2, 0, R, 2); add(8, 0, 0, 2, 0, R, 2);
    add(7, 1, 0, 0, 0, R, 2); add(1, 1, 0, 0, 0, H, 2); add(8, 0, 0, 0, 0, H, 2);
    // abort beats simultaneous final instr_done
    add(7, 0, 1, 1, 0, H, 2); add(1, 0, 1, 1, 0, S, 2); add(8, 0, 0, 1, 0, S, 2);
    add(7, 1, 0, 1, 0, S, 2); add(1, 1, 0, 1, 1, R, 2); add(6, 0, 0, 0, 0, R, 2);

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", outs(), {H, 8'd0});
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      change_btn = vecs[i].chg;
      step_btn   = vecs[i].stp;
      burst_len  = vecs[i].bl;
      instr_done = vecs[i].done;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), outs(), {vecs[i].st, vecs[i].cnt});
    end

    // asynchronous reset mid-cycle while in RUN with a nonzero count
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", outs(), {H, 8'd0});

    // button held high through reset release is a fresh press
    change_btn = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("after_release", outs(), {H, 8'd0});
    repeat (7) @(posedge clock);
    #1;
    check("held_edge7", outs(), {H, 8'd0});
    @(posedge clock);
    #1;
    check("held_edge8", outs(), {R, 8'd0});
    change_btn = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    change_btn = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    change_btn = 1'b0;
    check("back_halt", outs(), {H, 8'd0});
    repeat (8) @(posedge clock);
    #1;

    // step_count wrap
    for (int i = 0; i < 255; i++) do_burst();
    check("count_255", outs(), {H, 8'd255});
    do_burst();
    check("count_wrap", outs(), {H, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized cycles needed to accept a button level (legal range 1..255).
REQ-002 SHALL have port clock, input, 1, single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port change_btn, input, 1, raw asynchronous run/halt toggle button.
REQ-005 SHALL have port step_btn, input, 1, raw asynchronous single-step button.
REQ-006 SHALL have port burst_len, input, 4, instructions per step request, sampled on step acceptance.
REQ-007 SHALL have port instr_done, input, 1, core pulse, one cycle per retired instruction.
REQ-008 SHALL have port run_en, output, 1, core advance enable.
REQ-009 SHALL have port mode_run, output, 1, high only in RUN.
REQ-010 SHALL have port busy, output, 1, high only in STEP.
REQ-011 SHALL have port step_count, output, 8, completed step bursts, modulo 256.

Function
REQ-012 SHALL pass each button through a two-flop synchronizer.
REQ-013 SHALL count consecutive cycles where the synchronized level differs from the debounced level; on reaching DEBOUNCE_CYCLES, flip the debounced level and clear the count; any equal cycle clears the count.
REQ-014 SHALL register a one-cycle pulse on each debounced rising edge; falling edges produce nothing.
REQ-015 SHALL change state on the edge where the pulse is high: run_en changes DEBOUNCE_CYCLES+4 edges after the first edge sampling the raw button high.
REQ-016 SHALL implement states HALT, RUN, STEP; run_en = (RUN or STEP), decoded from the state register.
REQ-017 HALT: change pulse -> RUN; step pulse -> STEP with remaining = burst_len, burst_len 0 treated as 1.
REQ-018 HALT, both pulses same cycle: change wins, step discarded.
REQ-019 RUN: change pulse -> HALT; step pulses ignored; instr_done ignored.
REQ-020 STEP: each instr_done decrements remaining; instr_done with remaining = 1 -> HALT, step_count increments the same edge.
REQ-021 STEP: change pulse -> RUN, burst aborted, remaining cleared, step_count unchanged; takes priority over simultaneous final instr_done.
REQ-022 STEP: step pulses ignored; burst_len changes after acceptance have no effect.
REQ-023 step_count SHALL wrap 255 -> 0.
REQ-024 HALT: instr_done SHALL be ignored.

Reset
REQ-025 Reset low SHALL immediately force HALT, run_en=0, mode_run=0, busy=0, step_count=0, remaining=0, synchronizers, debounced levels, counters and edge pulses 0.
REQ-026 A button held high through reset release SHALL be accepted as a new press after sync+debounce.

Structure
REQ-027 Package step_ctrl_pkg SHALL hold the state typedef (HALT, RUN, STEP) and the default DEBOUNCE_CYCLES constant.
REQ-028 Sub-module btn_debounce (synchronizer, debounce counter, rising-edge pulse) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Release reset, hold change_btn high 12 cycles -> run_en and mode_run rise at 8th edge after first sampling, step_count=0.
REQ-030 change_btn high 3 cycles then low -> no pulse, state stays HALT, run_en=0.
REQ-031 burst_len=3, press step_btn, three instr_done pulses -> busy/run_en high until the edge of the 3rd pulse, then HALT, step_count 0->1.
REQ-032 burst_len=0, press step_btn, one instr_done -> HALT, step_count=1.
REQ-033 burst_len=5, step, 2 instr_done, press change_btn -> RUN, mode_run=1, busy=0, step_count unchanged.
REQ-034 In RUN, drive reset low mid-cycle -> run_en=0 before next clock edge, step_count=0; after release, state HALT.
